// File: rtl/uart_tx_fifo_if.sv
// Host push port plus the transmitter handshake of uart_tx_fifo.
// The master modport is the surrounding logic; the slave modport is the FIFO.
interface uart_tx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              busy;
    logic              TxEnable;
    logic [7:0]        TxData;
    logic              TxDone;

    modport master (
        output wr_en, wr_data, TxDone,
        input  full, empty, count, overflow, busy, TxEnable, TxData
    );

    modport slave (
        input  wr_en, wr_data, TxDone,
        output full, empty, count, overflow, busy, TxEnable, TxData
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter; issues one frame at a time.
//
// state | meaning
// IDLE  | nothing in flight; waits for a stored byte
// ISSUE | TxEnable high for one cycle; head byte is popped on exit
// WAIT  | frame on the line; waits for TxDone
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic          tck,
    input  logic          reset,
    uart_tx_fifo_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   count_q;
    logic [7:0]        tx_data_q;
    logic              tx_enable_q;
    logic              overflow_q;
    logic              pop;
    logic              push;
    logic              load_tx;

    // A push at full still fits when the head byte leaves on the same edge.
    assign pop  = (state == ISSUE);
    assign push = bus.wr_en && ((count_q != CNT_FULL) || pop);

    always_comb begin
        state_nxt = state;
        load_tx   = 1'b0;
        case (state)
            IDLE: begin
                if (count_q != '0) begin
                    state_nxt = ISSUE;
                    load_tx   = 1'b1;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (bus.TxDone) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge tck or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge tck or negedge reset) begin
        if (!reset) begin
            wptr        <= '0;
            rptr        <= '0;
            count_q     <= '0;
            tx_data_q   <= 8'h00;
            tx_enable_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // TxData is only reloaded here so it holds through the whole frame.
            if (load_tx) tx_data_q <= mem[rptr];
            tx_enable_q <= load_tx;
            overflow_q  <= bus.wr_en && !push;
        end
    end

    always_ff @(posedge tck) begin
        if (push) mem[wptr] <= bus.wr_data;
    end

    assign bus.count    = count_q;
    assign bus.full     = (count_q == CNT_FULL);
    assign bus.empty    = (count_q == '0);
    assign bus.overflow = overflow_q;
    assign bus.busy     = (state != IDLE);
    assign bus.TxEnable = tx_enable_q;
    assign bus.TxData   = tx_data_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference model, cycle compare, transmitter stand-in.
module tb_uart_tx_fifo;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int LINK_FREE = 0, LINK_REQ = 1, LINK_SENDING = 2;

    logic tck = 1'b0;
    logic reset;

    uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus_if ();

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .tck   (tck),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 tck = ~tck;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model: stored bytes, link status towards the transmitter
    logic [7:0] m_q[$];
    logic [7:0] m_txdata = 8'h00;
    int         m_link   = LINK_FREE;
    logic       m_ovf    = 1'b0;
    logic [7:0] acc_log[$];
    logic [7:0] sent[$];

    // transmitter stand-in
    int tx_delay   = 3;
    bit tx_manual  = 1'b0;
    bit force_done = 1'b0;
    bit tx_active  = 1'b0;
    int tx_timer   = 0;

    bit gap_on    = 1'b0;
    int last_done = -1;

    logic [17:0] exp_vec;
    logic [17:0] got_vec;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge tck);
            cyc++;
            if (reset !== 1'b1) begin
                m_q.delete();
                m_link   = LINK_FREE;
                m_txdata = 8'h00;
                m_ovf    = 1'b0;
            end else begin
                bit pop_now;
                bit acc;
                pop_now = (m_link == LINK_REQ);
                acc     = bus_if.wr_en && ((m_q.size() < DEPTH) || pop_now);
                m_ovf   = bus_if.wr_en && !acc;
                if (m_link == LINK_FREE) begin
                    if (m_q.size() != 0) begin
                        m_link   = LINK_REQ;
                        m_txdata = m_q[0];
                    end
                end else if (m_link == LINK_REQ) begin
                    m_link = LINK_SENDING;
                end else if (bus_if.TxDone === 1'b1) begin
                    m_link = LINK_FREE;
                end
                if (pop_now) void'(m_q.pop_front());
                if (acc) begin
                    m_q.push_back(bus_if.wr_data);
                    acc_log.push_back(bus_if.wr_data);
                end
            end
        end
    end

    always @(negedge tck) begin
        if (reset === 1'b1) begin
            exp_vec = {m_link == LINK_REQ, m_txdata, (ADDR_W+1)'(m_q.size()),
                       m_q.size() == DEPTH, m_q.size() == 0, m_ovf, m_link != LINK_FREE};
            got_vec = {bus_if.TxEnable, bus_if.TxData, bus_if.count, bus_if.full,
                       bus_if.empty, bus_if.overflow, bus_if.busy};
            total++;
            if (got_vec !== exp_vec) begin
                bad++;
                $display("FAIL cycle_cmp cyc=%0d {en,data,cnt,full,empty,ovf,busy}: got %b %h %0d %b%b%b%b want %b %h %0d %b%b%b%b",
                         cyc, got_vec[17], got_vec[16:9], got_vec[8:4], got_vec[3], got_vec[2], got_vec[1], got_vec[0],
                         exp_vec[17], exp_vec[16:9], exp_vec[8:4], exp_vec[3], exp_vec[2], exp_vec[1], exp_vec[0]);
            end
            if (bus_if.TxDone === 1'b1) last_done = cyc;
            if (bus_if.TxEnable === 1'b1) begin
                sent.push_back(bus_if.TxData);
                if (gap_on && last_done >= 0) check("done_to_enable_gap", cyc - last_done, 2);
            end
        end
    end

    initial begin
        bus_if.TxDone = 1'b0;
        forever begin
            @(posedge tck);
            #1;
            bus_if.TxDone = 1'b0;
            if (force_done) begin
                bus_if.TxDone = 1'b1;
                force_done    = 1'b0;
                tx_active     = 1'b0;
            end else if (tx_active) begin
                if (!tx_manual) begin
                    if (tx_timer <= 1) begin
                        bus_if.TxDone = 1'b1;
                        tx_active     = 1'b0;
                    end else begin
                        tx_timer--;
                    end
                end
            end else if (bus_if.TxEnable === 1'b1) begin
                tx_active = 1'b1;
                tx_timer  = tx_delay;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cycle();
        @(posedge tck);
        #3;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus_if.wr_en   = 1'b1;
        bus_if.wr_data = b;
        cycle();
        bus_if.wr_en   = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_txen"},  bus_if.TxEnable, 0);
        check({tag, "_txdata"}, bus_if.TxData, 8'h00);
        check({tag, "_count"}, bus_if.count, 0);
        check({tag, "_empty"}, bus_if.empty, 1);
        check({tag, "_full"},  bus_if.full, 0);
        check({tag, "_ovf"},   bus_if.overflow, 0);
        check({tag, "_busy"},  bus_if.busy, 0);
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while (!(bus_if.busy === 1'b0 && bus_if.empty === 1'b1) && n < max_cyc) begin
            cycle();
            n++;
        end
        check("drain_busy", bus_if.busy, 0);
    endtask

    task automatic wait_signal_high(input string name, input int max_cyc, input bit which_txen);
        int n = 0;
        while (((which_txen ? bus_if.TxEnable : bus_if.TxDone) !== 1'b1) && n < max_cyc) begin
            cycle();
            n++;
        end
        check(name, which_txen ? bus_if.TxEnable : bus_if.TxDone, 1);
    endtask

    initial begin
        logic [7:0] exp_list[$];

        reset          = 1'b1;
        bus_if.wr_en   = 1'b0;
        bus_if.wr_data = 8'h00;
        #1 reset = 1'b0;
        #2 check_reset("por");
        repeat (3) cycle();
        reset = 1'b1;
        repeat (5) begin
            cycle();
            check("idle_no_txen", bus_if.TxEnable, 0);
        end

        // reset while bytes are queued and one is in flight
        push_byte(8'h31);
        push_byte(8'h32);
        push_byte(8'h33);
        repeat (3) cycle();
        reset = 1'b0;
        #1 check_reset("mid");
        cycle();
        cycle();
        reset = 1'b1;
        repeat (6) begin
            cycle();
            check("post_rst_no_txen", bus_if.TxEnable, 0);
        end
        repeat (10) cycle();

        // single byte
        sent.delete();
        tx_delay = 5;
        push_byte(8'hA5);
        check("single_count1", bus_if.count, 1);
        check("single_txen_early", bus_if.TxEnable, 0);
        cycle();
        check("single_txen", bus_if.TxEnable, 1);
        check("single_txdata", bus_if.TxData, 8'hA5);
        cycle();
        check("single_txen_off", bus_if.TxEnable, 0);
        check("single_count0", bus_if.count, 0);
        check("single_busy", bus_if.busy, 1);
        wait_signal_high("single_txdone_seen", 50, 1'b0);
        check("single_busy_at_done", bus_if.busy, 1);
        cycle();
        check("single_busy_after", bus_if.busy, 0);
        check("single_txdata_hold", bus_if.TxData, 8'hA5);
        check("single_sent_n", sent.size(), 1);
        repeat (5) cycle();

        // ordering with a 20-cycle frame
        sent.delete();
        tx_delay  = 20;
        last_done = -1;
        gap_on    = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus_if.wr_en   = 1'b1;
            bus_if.wr_data = 8'(i);
            cycle();
        end
        bus_if.wr_en = 1'b0;
        wait_drain(400);
        gap_on = 1'b0;
        check("order_n", sent.size(), 4);
        for (int i = 0; i < 4 && i < sent.size(); i++) check("order_byte", sent[i], i + 1);
        repeat (5) cycle();

        // full, overflow, simultaneous push/pop at full
        sent.delete();
        tx_manual = 1'b1;
        push_byte(8'hEE);
        repeat (3) cycle();
        for (int i = 0; i < 16; i++) begin
            bus_if.wr_en   = 1'b1;
            bus_if.wr_data = 8'h10 + 8'(i);
            cycle();
        end
        bus_if.wr_en = 1'b0;
        check("full_count", bus_if.count, 16);
        check("full_flag", bus_if.full, 1);
        check("full_empty", bus_if.empty, 0);
        push_byte(8'hFF);
        check("ovf_pulse", bus_if.overflow, 1);
        check("ovf_count", bus_if.count, 16);
        cycle();
        check("ovf_clear", bus_if.overflow, 0);
        check("ovf_count2", bus_if.count, 16);
        force_done = 1'b1;
        wait_signal_high("simul_issue_seen", 20, 1'b1);
        check("simul_count_issue", bus_if.count, 16);
        push_byte(8'h77);
        check("simul_count", bus_if.count, 16);
        check("simul_ovf", bus_if.overflow, 0);
        check("simul_full", bus_if.full, 1);
        tx_delay  = 2;
        tx_manual = 1'b0;
        wait_drain(1000);
        exp_list.delete();
        exp_list.push_back(8'hEE);
        for (int i = 0; i < 16; i++) exp_list.push_back(8'h10 + 8'(i));
        exp_list.push_back(8'h77);
        check("drain_n", sent.size(), exp_list.size());
        for (int i = 0; i < exp_list.size() && i < sent.size(); i++) check("drain_byte", sent[i], exp_list[i]);
        repeat (5) cycle();

        // random traffic wrapping the pointers
        sent.delete();
        acc_log.delete();
        for (int i = 0; i < 40; i++) begin
            tx_delay = int'($urandom_range(1, 3));
            push_byte(8'($urandom));
            repeat ($urandom_range(2, 6)) cycle();
        end
        wait_drain(2000);
        check("wrap_n", sent.size(), acc_log.size());
        check("wrap_min", acc_log.size() >= 32, 1);
        for (int i = 0; i < acc_log.size() && i < sent.size(); i++) check("wrap_byte", sent[i], acc_log[i]);
        repeat (5) cycle();

        // reset while waiting for TxDone
        sent.delete();
        tx_manual = 1'b1;
        push_byte(8'h5A);
        repeat (3) cycle();
        check("wait_busy", bus_if.busy, 1);
        check("wait_txen", bus_if.TxEnable, 0);
        reset = 1'b0;
        #1 check_reset("wait_rst");
        cycle();
        cycle();
        reset = 1'b1;
        force_done = 1'b1;
        repeat (8) begin
            cycle();
            check("late_done_no_txen", bus_if.TxEnable, 0);
            check("late_done_count", bus_if.count, 0);
        end
        check("late_done_sent", sent.size(), 1);
        tx_manual = 1'b0;
        repeat (3) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
